// File: rtl/plastic_neuron_array_pkg.sv
// Shared types and defaults for the plastic neuron array.
package plastic_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MAC      = 3'd1,
    OUT      = 3'd2,
    WAIT_ERR = 3'd3,
    LEARN    = 3'd4
  } state_t;

  localparam int N_IN_DEF   = 4;
  localparam int DATA_W_DEF = 16;
  localparam int W_W_DEF    = 16;
  localparam int ACC_W_DEF  = 40;
  localparam int LR_DEF     = 20;
  localparam int W_INIT_DEF = 1058;
  localparam int W_MIN_DEF  = -32000;
  localparam int W_MAX_DEF  = 32000;

  function automatic int idx_w(input int n);
    idx_w = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plastic_neuron_array_weight_update.sv
// Sign-Hebbian step for one synapse: moves the weight by the learning rate
// towards the error sign when the input was positive, clamped to [W_MIN, W_MAX].
module plastic_weight_update #(
  parameter int DATA_W        = 16,
  parameter int W_W           = 16,
  parameter int LEARNING_RATE = 20,
  parameter int W_MIN         = -32000,
  parameter int W_MAX         = 32000
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] e,
  input  logic signed [W_W-1:0]    w_old,
  output logic signed [W_W-1:0]    w_new
);

  localparam logic signed [DATA_W-1:0] ZERO_D  = '0;
  localparam logic signed [W_W:0]      LR_EXT  = (W_W+1)'(LEARNING_RATE);
  localparam logic signed [W_W:0]      MIN_EXT = (W_W+1)'(W_MIN);
  localparam logic signed [W_W:0]      MAX_EXT = (W_W+1)'(W_MAX);

  logic signed [W_W:0] w_ext_s;
  logic signed [W_W:0] inc_s;
  logic signed [W_W:0] dec_s;

  // One extra bit of headroom so the step can never wrap before clamping
  always_comb begin
    w_ext_s = {w_old[W_W-1], w_old};
    inc_s   = w_ext_s + LR_EXT;
    dec_s   = w_ext_s - LR_EXT;
    w_new   = w_old;
    if ((x > ZERO_D) && (e > ZERO_D)) begin
      if (inc_s > MAX_EXT) begin
        w_new = MAX_EXT[W_W-1:0];
      end else begin
        w_new = inc_s[W_W-1:0];
      end
    end else if ((x > ZERO_D) && (e < ZERO_D)) begin
      if (dec_s < MIN_EXT) begin
        w_new = MIN_EXT[W_W-1:0];
      end else begin
        w_new = dec_s[W_W-1:0];
      end
    end else begin
      w_new = w_old;
    end
  end

endmodule

// File: rtl/plastic_neuron_array.sv
// Plastic neuron: serial MAC of a latched input vector against per-synapse
// weights, followed by an optional error-driven sign-Hebbian weight pass.
import plastic_pkg::*;

module plastic_neuron_array #(
  parameter int N_IN          = N_IN_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int W_W           = W_W_DEF,
  parameter int ACC_W         = ACC_W_DEF,
  parameter int LEARNING_RATE = LR_DEF,
  parameter int W_INIT        = W_INIT_DEF,
  parameter int W_MIN         = W_MIN_DEF,
  parameter int W_MAX         = W_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     learn_en,
  input  logic                     err_valid,
  output logic                     err_ready,
  input  logic signed [DATA_W-1:0] err_data,
  output logic                     busy
);

  localparam int                  IDX_W    = idx_w(N_IN);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic signed [W_W-1:0] W_INIT_V = W_W'(W_INIT);

  state_t                     state_r;
  logic [N_IN*DATA_W-1:0]     x_vec_r;
  logic signed [W_W-1:0]      w_r [N_IN];
  logic signed [ACC_W-1:0]    acc_r;
  logic [IDX_W-1:0]           idx_r;
  logic signed [DATA_W-1:0]   e_r;
  logic                       in_ready_r;
  logic                       err_ready_r;
  logic                       busy_r;
  logic                       out_valid_r;
  logic signed [ACC_W-1:0]    out_data_r;

  logic signed [DATA_W-1:0]     x_arr_s [N_IN];
  logic signed [DATA_W-1:0]     x_sel_s;
  logic signed [W_W-1:0]        w_sel_s;
  logic signed [DATA_W+W_W-1:0] prod_s;
  logic signed [ACC_W-1:0]      acc_next_s;
  logic signed [W_W-1:0]        w_new_s;

  // Unpack the latched vector so the shared index can select one sample
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      x_arr_s[i] = x_vec_r[i*DATA_W +: DATA_W];
    end
  end

  assign x_sel_s    = x_arr_s[idx_r];
  assign w_sel_s    = w_r[idx_r];
  assign prod_s     = x_sel_s * w_sel_s;
  assign acc_next_s = acc_r + ACC_W'(prod_s);

  plastic_weight_update #(
    .DATA_W        (DATA_W),
    .W_W           (W_W),
    .LEARNING_RATE (LEARNING_RATE),
    .W_MIN         (W_MIN),
    .W_MAX         (W_MAX)
  ) u_update (
    .x     (x_sel_s),
    .e     (e_r),
    .w_old (w_sel_s),
    .w_new (w_new_s)
  );

  // Control FSM with datapath registers; ready/busy flags track the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      x_vec_r     <= '0;
      acc_r       <= '0;
      idx_r       <= '0;
      e_r         <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      err_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        w_r[i] <= W_INIT_V;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            x_vec_r    <= in_data;
            acc_r      <= '0;
            idx_r      <= '0;
            state_r    <= MAC;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          if (idx_r == IDX_LAST) begin
            out_data_r  <= acc_next_s;
            out_valid_r <= 1'b1;
            idx_r       <= '0;
            state_r     <= OUT;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (learn_en) begin
              state_r     <= WAIT_ERR;
              err_ready_r <= 1'b1;
            end else begin
              state_r    <= IDLE;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b0;
            end
          end
        end
        WAIT_ERR: begin
          if (err_valid && err_ready_r) begin
            e_r         <= err_data;
            idx_r       <= '0;
            state_r     <= LEARN;
            err_ready_r <= 1'b0;
          end
        end
        LEARN: begin
          w_r[idx_r] <= w_new_s;
          if (idx_r == IDX_LAST) begin
            idx_r      <= '0;
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          err_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign err_ready = err_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_plastic_neuron_array.sv
// Bench: three neuron instances (default, low W_MAX, W_INIT at W_MIN) share one
// stimulus bus and are checked every cycle against a transaction-level model.
module tb_plastic_neuron_array;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int LR = 20;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [N*DW-1:0] in_data;
  logic out_ready;
  logic learn_en;
  logic err_valid;
  logic signed [DW-1:0] err_data;

  logic ir [3];
  logic ov [3];
  logic er [3];
  logic bz [3];
  logic signed [AW-1:0] od [3];

  int w_init_p [3] = '{1058, 1058, -32000};
  int w_max_p  [3] = '{32000, 1070, 32000};
  int w_min_p  [3] = '{-32000, -32000, -32000};

  int     mw [3][N];
  longint exp_out [3];
  longint last_out [3];

  bit chk_en, chk_od0;
  bit e_ir, e_er, e_bz, e_ov;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  plastic_neuron_array u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .learn_en(learn_en),
    .err_valid(err_valid), .err_ready(er[0]), .err_data(err_data), .busy(bz[0]));

  plastic_neuron_array #(.W_MAX(1070)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .learn_en(learn_en),
    .err_valid(err_valid), .err_ready(er[1]), .err_data(err_data), .busy(bz[1]));

  plastic_neuron_array #(.W_INIT(-32000)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .learn_en(learn_en),
    .err_valid(err_valid), .err_ready(er[2]), .err_data(err_data), .busy(bz[2]));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Per-cycle comparison of every instance against the expected handshake view
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready[%0d]", k), longint'(ir[k]), longint'(e_ir));
        chk($sformatf("err_ready[%0d]", k), longint'(er[k]), longint'(e_er));
        chk($sformatf("busy[%0d]", k), longint'(bz[k]), longint'(e_bz));
        chk($sformatf("out_valid[%0d]", k), longint'(ov[k]), longint'(e_ov));
        if (e_ov) chk($sformatf("out_data[%0d]", k), longint'(od[k]), exp_out[k]);
        if (chk_od0) chk($sformatf("out_data_rst[%0d]", k), longint'(od[k]), 64'sd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_ir = 1'b1; e_er = 1'b0; e_bz = 1'b0; e_ov = 1'b0;
  endtask

  function automatic logic [N*DW-1:0] pk(input int a, input int b, input int c, input int d);
    pk = {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_valid = 1'b0; learn_en = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) mw[k][i] = w_init_p[k];
    set_idle_exp();
    chk_od0 = 1'b1;
    chk_en  = 1'b1;
  endtask

  // abort: 0 = complete, 1 = reset in MAC at idx 2, 2 = reset in LEARN at idx 1
  task automatic run(input logic [N*DW-1:0] xv, input bit learn, input int e,
                     input int hold, input int abort);
    int xi;
    longint s;
    for (int k = 0; k < 3; k++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        xi = int'($signed(xv[i*DW +: DW]));
        s += longint'(xi) * longint'(mw[k][i]);
      end
      exp_out[k] = s;
    end
    set_idle_exp();
    in_valid = 1'b1; in_data = xv;
    tick();
    e_ir = 1'b0; e_bz = 1'b1;
    in_data = ~xv;
    if (abort == 1) begin
      tick(); tick();
      do_reset();
      return;
    end
    repeat (N) tick();
    in_valid = 1'b0; e_ov = 1'b1; chk_od0 = 1'b0;
    for (int h = 0; h < hold; h++) begin
      err_valid = h[0]; err_data = 16'sd9;
      tick();
    end
    err_valid = 1'b0; out_ready = 1'b1; learn_en = learn;
    for (int k = 0; k < 3; k++) last_out[k] = longint'(od[k]);
    tick();
    out_ready = 1'b0; learn_en = 1'b0; e_ov = 1'b0;
    if (!learn) begin
      set_idle_exp();
      return;
    end
    e_er = 1'b1;
    tick(); tick();
    err_valid = 1'b1; err_data = e[15:0];
    tick();
    err_valid = 1'b0; e_er = 1'b0;
    if (abort == 2) begin
      tick();
      do_reset();
      return;
    end
    repeat (N) tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        xi = int'($signed(xv[i*DW +: DW]));
        if (xi > 0 && e > 0)
          mw[k][i] = (mw[k][i] + LR > w_max_p[k]) ? w_max_p[k] : mw[k][i] + LR;
        else if (xi > 0 && e < 0)
          mw[k][i] = (mw[k][i] - LR < w_min_p[k]) ? w_min_p[k] : mw[k][i] - LR;
      end
    end
    set_idle_exp();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; learn_en = 1'b0;
    err_valid = 1'b0; err_data = '0;
    chk_en = 1'b0; chk_od0 = 1'b0;
    e_ir = 1'b0; e_er = 1'b0; e_bz = 1'b0; e_ov = 1'b0;
    tick();
    do_reset();

    run(pk(1, 2, 3, 4), 1'b0, 0, 0, 0);
    chk("lit_basic", last_out[0], 64'sd10580);
    run(pk(1, -2, 0, 3), 1'b1, 5, 10, 0);
    run(pk(1, 1, 1, 1), 1'b0, 0, 2, 0);
    chk("lit_after_pos_err", last_out[0], 64'sd4272);

    do_reset();
    run(pk(1, -2, 0, 3), 1'b1, -5, 0, 0);
    run(pk(1, -2, 0, 3), 1'b1, 0, 1, 0);
    run(pk(1, 1, 1, 1), 1'b0, 0, 0, 0);
    chk("lit_after_neg_zero_err", last_out[0], 64'sd4192);

    do_reset();
    run(pk(7, 7, 7, 7), 1'b1, 1, 0, 0);
    run(pk(1, 1, 1, 1), 1'b0, 0, 0, 0);
    chk("lit_clamp_max", last_out[1], 64'sd4280);
    chk("lit_no_clamp", last_out[0], 64'sd4312);

    do_reset();
    run(pk(-32768, -32768, -32768, -32768), 1'b0, 0, 3, 0);
    chk("lit_extreme", last_out[2], 64'sd4194304000);

    run(pk(1, 2, 3, 4), 1'b0, 0, 0, 1);
    run(pk(1, 2, 3, 4), 1'b0, 0, 0, 0);
    chk("lit_after_mac_abort", last_out[0], 64'sd10580);
    run(pk(1, 2, 3, 4), 1'b1, 5, 0, 2);
    run(pk(1, 2, 3, 4), 1'b0, 0, 0, 0);
    chk("lit_after_learn_abort", last_out[0], 64'sd10580);

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/plastic_neuron_array.md
Name: plastic_neuron_array

Overview:
Parametrised next-generation plastic neuron with N_IN synapses, each holding its own signed weight register. Computes a serial multiply-accumulate of a packed input vector against the weights over N_IN cycles. Optionally applies a sign-Hebbian update to every weight, driven by an error handshake. Uses valid/ready on input, output and error so it can sit between streaming stages of the silicon-soul datapath.

Parameters:
N_IN, 4, number of synapses (>=2)
DATA_W, 16, signed input sample width
W_W, 16, signed weight width
ACC_W, 40, signed accumulator/output width; must be >= DATA_W+W_W+clog2(N_IN), so no overflow is possible
LEARNING_RATE, 20, unsigned weight step per update
W_INIT, 1058, reset value of every weight
W_MIN, -32000, lower weight clamp (signed)
W_MAX, 32000, upper weight clamp (signed)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset: state is reset on a clk edge when rst==0
in_valid  in  1  input vector valid
in_ready  out  1  high only in IDLE
in_data  in  N_IN*DATA_W  packed signed samples; element i at bits [i*DATA_W +: DATA_W]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  signed sum of x_i*w_i
learn_en  in  1  sampled at the output handshake
err_valid  in  1  feedback error valid
err_ready  out  1  high only in WAIT_ERR
err_data  in  DATA_W  signed feedback error
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; all weights=W_INIT; acc=0; idx=0; out_data=0; out_valid=0; busy=0. A reset that lands mid-MAC or mid-LEARN aborts the operation, and partial weight updates are lost.
- Ready outputs are decoded from state: in_ready=(state==IDLE), err_ready=(state==WAIT_ERR).
- FSM states: IDLE, MAC, OUT, WAIT_ERR, LEARN.
- IDLE: on in_valid&&in_ready, latch in_data into x_reg, set acc=0 and idx=0, and go to MAC.
- MAC: each cycle, acc += signed(x_reg[idx])*signed(w[idx]), fully sign-extended to ACC_W, then idx++. After the idx==N_IN-1 edge, out_data is loaded with the final sum and state becomes OUT.
- Latency: out_valid rises exactly N_IN cycles after the accepting edge.
- OUT: out_valid=1. out_data is held stable while out_ready==0.
- On the output handshake (out_valid&&out_ready), out_valid drops next cycle. If learn_en==1, go to WAIT_ERR; otherwise go to IDLE.
- WAIT_ERR: on err_valid&&err_ready, latch err_data into e_reg, set idx=0, and go to LEARN. Waits indefinitely until then.
- LEARN: one synapse per cycle, using the latched x_reg (the inputs that produced the result):
  - x_i>0 and e>0: w_i = min(w_i+LR, W_MAX)
  - x_i>0 and e<0: w_i = max(w_i-LR, W_MIN)
  - x_i<=0 or e==0: w_i unchanged
  - All comparisons are signed. Clamping is computed in W_W+1 bits, so wrap-around is impossible.
  - After idx==N_IN-1, go to IDLE.
- Weights are never modified in MAC, OUT or IDLE. A new input is not accepted until the previous learn cycle completes, so a MAC never sees a half-updated weight set.
- Simultaneous events: in_valid asserted during a busy state is ignored (not latched). err_valid outside WAIT_ERR is ignored.

Decomposition:
- Shared package plastic_pkg: state enum (IDLE, MAC, OUT, WAIT_ERR, LEARN); default-parameter constants; a clog2-based index width helper.
- One natural sub-module, plastic_weight_update: combinational (x, e, w_old) -> w_new, applying the sign rule and clamping. It is instantiated once and shared via idx.

Test Plan:
- Defaults, in_data=[1,2,3,4], learn_en=0 -> out_valid exactly 4 cycles after accept; out_data=10580; in_ready low throughout; busy drops the cycle after the output handshake.
- in_data=[1,-2,0,3], learn_en=1, err_data=+5 -> weights become [1078,1058,1058,1078]. A follow-up input [1,1,1,1] gives out_data=4272.
- Same input with err_data=-5, then err_data=0 -> weights [1038,1058,1058,1038], then unchanged.
- W_MAX=1070, 1 learn cycle with x=[7,7,7,7], e=+1 -> every weight clamps to 1070 (not 1078). Extreme inputs: x=-32768 and all w=W_MIN, giving out_data=4*(-32768*-32000)=4194304000 with no overflow.
- Backpressure: out_ready held low 10 cycles -> out_data stable and in_ready=0 throughout. err_valid pulses while in OUT are ignored, and weights are unchanged.
- rst driven low during MAC idx=2 and again during LEARN idx=1 -> next cycle state=IDLE, out_valid=0, all weights=1058. A fresh [1,2,3,4] transaction then yields 10580.
